// File: rtl/cart_clk_mon_pkg.sv
// cart_clk_mon_pkg: shared state encoding, default timing constants and tolerance check for cart_clk_monitor
package cart_clk_mon_pkg;
  typedef enum logic [1:0] {RESET_PLL, WAIT_LOCK, MEASURE, RUNNING} state_e;
  localparam int unsigned REF_HZ               = 74_250_000;
  localparam int unsigned CART_HZ              = 6_285_402;
  localparam int unsigned DEF_RST_CYCLES       = 16;
  localparam int unsigned DEF_LOCK_STABLE      = 1024;
  localparam int unsigned DEF_LOCK_TIMEOUT     = REF_HZ / 100;
  localparam int unsigned DEF_WINDOW_CYCLES    = REF_HZ / 1000;
  localparam int unsigned DEF_EXPECTED_EDGES   = CART_HZ / 1000;
  localparam int unsigned DEF_TOLERANCE        = 8;
  // Inclusive on both bounds; written as cnt+tol >= exp so a tolerance larger than exp cannot underflow.
  function automatic logic in_tolerance(input logic [15:0] cnt, input int unsigned expected, input int unsigned tol);
    return (32'(cnt) + tol >= expected) && (32'(cnt) <= expected + tol);
  endfunction
endpackage

// File: rtl/cart_clk_sync.sv
// cart_clk_sync: 2-FF synchronizer for an asynchronous level into the clk_i domain
//   clk_i    in  sampling clock
//   reset_ni in  synchronous active-low reset (clears both stages)
//   d_i      in  asynchronous input
//   q_o      out synchronized level (second stage)
module cart_clk_sync
  import cart_clk_mon_pkg::*;
(
  input  logic clk_i,
  input  logic reset_ni,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] sync_q;
  always_ff @(posedge clk_i)
    sync_q <= !reset_ni ? 2'b00 : {sync_q[0], d_i};
  assign q_o = sync_q[1];
endmodule

// File: rtl/cart_clk_monitor.sv
// cart_clk_monitor: drives cart PLL reset, qualifies its lock and measures outclk edges per reference window
//   clk_74a        in  74.25 MHz reference clock
//   reset_n        in  synchronous active-low reset
//   pll_outclk     in  PLL output clock, sampled as asynchronous data
//   pll_locked     in  PLL lock, asynchronous
//   pll_rst        out PLL reset, active high, registered
//   clk_ok         out cart clock qualified and within tolerance, registered
//   measured_edges out edge count of the last completed window
//   retry_count    out PLL reset attempts since reset_n (saturating)
// Build option: CART_CLK_MON_STATS_EN enables retry_count and the fail_edges debug register;
// without it retry_count reads 0 and FSM behaviour is unchanged.
module cart_clk_monitor
  import cart_clk_mon_pkg::*;
#(
  parameter int unsigned RST_CYCLES     = DEF_RST_CYCLES,
  parameter int unsigned LOCK_STABLE    = DEF_LOCK_STABLE,
  parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int unsigned WINDOW_CYCLES  = DEF_WINDOW_CYCLES,
  parameter int unsigned EXPECTED_EDGES = DEF_EXPECTED_EDGES,
  parameter int unsigned TOLERANCE      = DEF_TOLERANCE
) (
  input  logic        clk_74a,
  input  logic        reset_n,
  input  logic        pll_outclk,
  input  logic        pll_locked,
  output logic        pll_rst,
  output logic        clk_ok,
  output logic [15:0] measured_edges,
  output logic [7:0]  retry_count
);
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT + RST_CYCLES + 1);
  localparam int unsigned SW = $clog2(LOCK_STABLE + 1);
  localparam int unsigned WW = $clog2(WINDOW_CYCLES + 1);
  state_e          state_q, state_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   stab_q, stab_d;
  logic [WW-1:0]   win_q, win_d;
  logic [15:0]     edges_q, edges_d, win_count, meas_q, meas_d;
  logic            clk_s, clk_prev_q, locked, rise;
  logic            active, win_end, win_pass;
  logic            pll_rst_q, clk_ok_q;
  cart_clk_sync u_clk_sync  (.clk_i(clk_74a), .reset_ni(reset_n), .d_i(pll_outclk), .q_o(clk_s));
  cart_clk_sync u_lock_sync (.clk_i(clk_74a), .reset_ni(reset_n), .d_i(pll_locked), .q_o(locked));
  // Third stage behind the outclk synchronizer gives a clean one-cycle rising-edge pulse.
  assign rise = clk_s & ~clk_prev_q;
  always_comb begin
    active    = state_q == MEASURE || state_q == RUNNING;
    win_end   = active && win_q == WW'(WINDOW_CYCLES - 1);
    win_count = (rise && edges_q != 16'hFFFF) ? edges_q + 16'd1 : edges_q;
    win_pass  = in_tolerance(win_count, EXPECTED_EDGES, TOLERANCE);
    stab_d    = (state_q == WAIT_LOCK && locked) ? stab_q + 1'b1 : '0;
    state_d   = state_q;
    case (state_q)
      RESET_PLL: state_d = cnt_q == TW'(RST_CYCLES - 1) ? WAIT_LOCK : RESET_PLL;
      WAIT_LOCK: state_d = stab_d == SW'(LOCK_STABLE) ? MEASURE :
                           cnt_q == TW'(LOCK_TIMEOUT - 1) ? RESET_PLL : WAIT_LOCK;
      // Lock loss beats a window end; the count is still latched below.
      default:   state_d = (!locked || (win_end && !win_pass)) ? RESET_PLL :
                           win_end ? RUNNING : state_q;
    endcase
    cnt_d   = (active || state_d != state_q) ? '0 : cnt_q + 1'b1;
    win_d   = (active && !win_end) ? win_q + 1'b1 : '0;
    edges_d = (active && !win_end) ? win_count : '0;
    meas_d  = win_end ? win_count : meas_q;
  end
  always_ff @(posedge clk_74a)
    if (!reset_n) begin
      state_q    <= RESET_PLL;
      cnt_q      <= '0;
      stab_q     <= '0;
      win_q      <= '0;
      edges_q    <= '0;
      meas_q     <= '0;
      clk_prev_q <= 1'b0;
      pll_rst_q  <= 1'b1;
      clk_ok_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stab_q     <= stab_d;
      win_q      <= win_d;
      edges_q    <= edges_d;
      meas_q     <= meas_d;
      clk_prev_q <= clk_s;
      pll_rst_q  <= state_d == RESET_PLL;
      clk_ok_q   <= state_d == RUNNING;
    end
`ifdef CART_CLK_MON_STATS_EN
  logic [7:0]  retry_q;
  logic [15:0] fail_edges_q;
  // The RESET_PLL held from reset_n is not a retry, so only transitions into it count.
  always_ff @(posedge clk_74a)
    if (!reset_n) begin
      retry_q      <= '0;
      fail_edges_q <= '0;
    end else begin
      if (state_d == RESET_PLL && state_q != RESET_PLL && retry_q != 8'hFF) retry_q <= retry_q + 8'd1;
      if (win_end && !win_pass) fail_edges_q <= win_count;
    end
  assign retry_count = retry_q;
`else
  assign retry_count = '0;
`endif
  assign pll_rst        = pll_rst_q;
  assign clk_ok         = clk_ok_q;
  assign measured_edges = meas_q;
endmodule
